song_sequencer: RTL and testbench

Sequences a stored song through the note player: fetches (period, duration) entries from an external song ROM, drives the note player's period and enable inputs for the required number of beats, and inserts a short articulation gap between notes. It sits above the note player controller/counter datapath and is the only block that writes its period/enable. Start/stop control and a done pulse let the top-level button logic trigger playback.

---
 rtl/song_sequencer_if.sv | 55 +++++
 rtl/song_sequencer.sv | 164 ++++++++++++++++
 tb/tb_song_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// ---------------------------------------------------------------------------
// song_sequencer_if
//
// Groups the song sequencer's control, song ROM and note player signals.
//
// Signals:
//   start          begin playback from entry 0
//   stop           abort playback
//   rom_addr       song ROM address (from the sequencer)
//   rom_data       {period, dur} at rom_addr (combinational ROM)
//   player_period  half-period to the note player
//   player_en      note player enable
//   busy           high in every sequencer state except IDLE
//   done           one-cycle pulse at normal end of song
//
// Modports:
//   master  the surrounding system (button logic, song ROM, note player)
//   slave   the song_sequencer itself
// ---------------------------------------------------------------------------
interface song_sequencer_if #(
    parameter int ADDR_W   = 4,
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 4
);
    logic                      start;
    logic                      stop;
    logic [ADDR_W-1:0]         rom_addr;
    logic [PERIOD_W+DUR_W-1:0] rom_data;
    logic [PERIOD_W-1:0]       player_period;
    logic                      player_en;
    logic                      busy;
    logic                      done;

    modport master (
        output start,
        output stop,
        output rom_data,
        input  rom_addr,
        input  player_period,
        input  player_en,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        input  rom_data,
        output rom_addr,
        output player_period,
        output player_en,
        output busy,
        output done
    );
endinterface

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
//
// Walks a stored song held in an external combinational ROM. Each entry is
// {period, dur}: the note is played for dur*BEAT_CYCLES - GAP_CYCLES cycles,
// followed by GAP_CYCLES of silence, with one FETCH cycle in front. An entry
// with dur = 0 marks the end of the song; running off the last ROM address
// also ends it. Sole writer of the note player's period/enable inputs.
//
// Ports:
//   clk   clock, all state changes on its rising edge
//   rst   synchronous active-low reset
//   bus   song_sequencer_if.slave: start, stop, rom_addr, rom_data,
//         player_period, player_en, busy, done
//
// Parameters:
//   ADDR_W, PERIOD_W, DUR_W   field widths
//   BEAT_CYCLES               clock cycles per beat (> GAP_CYCLES)
//   GAP_CYCLES                silent cycles at the end of each entry (>= 1)
//
// Build option:
//   SONG_SEQ_LOOP_EN  when defined, END restarts playback at entry 0 instead
//                     of returning to IDLE (an empty song still goes IDLE).
//
// All outputs come from registers or are decoded from registered state only.
// ---------------------------------------------------------------------------
module song_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int PERIOD_W    = 16,
    parameter int DUR_W       = 4,
    parameter int BEAT_CYCLES = 1000,
    parameter int GAP_CYCLES  = 50
) (
    input logic             clk,
    input logic             rst,
    song_sequencer_if.slave bus
);
    // Wide enough for the largest dur*BEAT_CYCLES product.
    localparam int CNT_W = $clog2((2 ** DUR_W) * BEAT_CYCLES);

    localparam logic [CNT_W-1:0]  BEAT_C    = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0]  GAP_C     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]  ONE_C     = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_PLAY,
        S_GAP,
        S_END
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt;
    logic [PERIOD_W-1:0] period, period_nxt;

    logic [PERIOD_W-1:0] rom_period;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_period = bus.rom_data[PERIOD_W+DUR_W-1:DUR_W];
    assign rom_dur    = bus.rom_data[DUR_W-1:0];

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            addr   <= '0;
            period <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr   <= addr_nxt;
            period <= period_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        addr_nxt   = addr;
        period_nxt = period;

        case (state)
            S_IDLE: begin
                // start together with stop is treated as no request.
                if (bus.start && !bus.stop) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = '0;
                end
            end

            S_FETCH: begin
                if (rom_dur == '0) begin
                    state_nxt = S_END;
                end else begin
                    // The counter runs down to 0 inclusive, hence the -1.
                    period_nxt = rom_period;
                    cnt_nxt    = CNT_W'(rom_dur) * BEAT_C - GAP_C - ONE_C;
                    state_nxt  = S_PLAY;
                end
            end

            S_PLAY: begin
                if (cnt == '0) begin
                    cnt_nxt   = GAP_C - ONE_C;
                    state_nxt = S_GAP;
                end else begin
                    cnt_nxt = cnt - ONE_C;
                end
            end

            S_GAP: begin
                if (cnt == '0) begin
                    // No wrap: the last ROM address always ends the song.
                    if (addr == LAST_ADDR) begin
                        state_nxt = S_END;
                    end else begin
                        addr_nxt  = addr + ADDR_ONE;
                        state_nxt = S_FETCH;
                    end
                end else begin
                    cnt_nxt = cnt - ONE_C;
                end
            end

            S_END: begin
                addr_nxt   = '0;
                period_nxt = '0;
                state_nxt  = S_IDLE;
`ifdef SONG_SEQ_LOOP_EN
                // addr is still the address that ended the song; 0 here can
                // only mean entry 0 was the marker, so don't loop an empty song.
                if (addr != '0) begin
                    state_nxt = S_FETCH;
                end
`endif
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // stop overrides everything in any active state.
        if ((state != S_IDLE) && bus.stop) begin
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
            addr_nxt   = '0;
            period_nxt = '0;
        end
    end

    assign bus.rom_addr      = addr;
    assign bus.player_period = period;
    assign bus.player_en     = (state == S_PLAY) && (period != '0);
    assign bus.busy          = (state != S_IDLE);
    assign bus.done          = (state == S_END);

endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
//
// Directed bench for song_sequencer with BEAT_CYCLES=4, GAP_CYCLES=1,
// ADDR_W=2. The stimulus process pushes the hand-derived expected output
// vector for every cycle into a queue; an independent monitor pops one entry
// per cycle on the falling edge and compares it with the DUT outputs.
// Honours SONG_SEQ_LOOP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_song_sequencer;

    localparam int ADDR_W   = 2;
    localparam int PERIOD_W = 16;
    localparam int DUR_W    = 4;
    localparam int BEAT     = 4;
    localparam int GAP      = 1;

    typedef struct {
        string               tag;
        logic                busy;
        logic                done;
        logic                en;
        logic [PERIOD_W-1:0] period;
        logic [ADDR_W-1:0]   addr;
    } exp_t;

    logic clk;
    logic rst;
    logic [PERIOD_W+DUR_W-1:0] rom [4];

    exp_t exp_q[$];
    int   num_checks;
    int   num_fail;

    song_sequencer_if #(
        .ADDR_W  (ADDR_W),
        .PERIOD_W(PERIOD_W),
        .DUR_W   (DUR_W)
    ) bus ();

    song_sequencer #(
        .ADDR_W     (ADDR_W),
        .PERIOD_W   (PERIOD_W),
        .DUR_W      (DUR_W),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PERIOD_W+DUR_W-1:0] ent(input logic [PERIOD_W-1:0] p,
                                                       input logic [DUR_W-1:0] d);
        return {p, d};
    endfunction

    // Advance n cycles; for each, queue the outputs expected after that edge.
    task automatic apply_stimulus(input int n, input string tag,
                                  input logic busy, input logic done, input logic en,
                                  input logic [PERIOD_W-1:0] period,
                                  input logic [ADDR_W-1:0] addr);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            e.tag    = tag;
            e.busy   = busy;
            e.done   = done;
            e.en     = en;
            e.period = period;
            e.addr   = addr;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        apply_stimulus(n, tag, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // END cycle of a normally finishing song, then IDLE. In the looping
    // build stop is raised during END so the song does not restart.
    task automatic finish_song(input string tag, input logic [PERIOD_W-1:0] p,
                               input logic [ADDR_W-1:0] a);
        apply_stimulus(1, {tag, "_end"}, 1'b1, 1'b1, 1'b0, p, a);
`ifdef SONG_SEQ_LOOP_EN
        bus.stop = 1'b1;
`endif
        idle_cycles(1, {tag, "_back_idle"});
        bus.stop = 1'b0;
    endtask

    task automatic check_output(input exp_t e);
        num_checks++;
        if (bus.busy !== e.busy || bus.done !== e.done || bus.player_en !== e.en ||
            bus.player_period !== e.period || bus.rom_addr !== e.addr) begin
            num_fail++;
            $display("[TB] FAIL %s @%0t: got busy=%0b done=%0b en=%0b period=%h addr=%0d, want busy=%0b done=%0b en=%0b period=%h addr=%0d",
                     e.tag, $time, bus.busy, bus.done, bus.player_en, bus.player_period,
                     bus.rom_addr, e.busy, e.done, e.en, e.period, e.addr);
        end
    endtask

    // Monitor: one expected vector per cycle, checked on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check_output(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [PERIOD_W-1:0] full_p [4];
        num_checks = 0;
        num_fail   = 0;
        rst        = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = '0;

        // Reset held for 2 cycles, then released with start low.
        idle_cycles(2, "reset_hold");
        rst = 1'b1;
        idle_cycles(5, "reset_idle");

        // start and stop together in IDLE: stay IDLE.
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        idle_cycles(1, "idle_start_stop");
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        idle_cycles(1, "idle");

        // Two notes then end marker: done 16 cycles after start is sampled.
        $display("[TB] basic song");
        rom[0] = ent(16'h0010, 4'd1);
        rom[1] = ent(16'h0020, 4'd2);
        rom[2] = ent(16'h0000, 4'd0);
        rom[3] = ent(16'h0055, 4'd3);
        bus.start = 1'b1;
        apply_stimulus(1, "s1_fetch0", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
        bus.start = 1'b0;
        apply_stimulus(3, "s1_play0",  1'b1, 1'b0, 1'b1, 16'h0010, 2'd0);
        apply_stimulus(1, "s1_gap0",   1'b1, 1'b0, 1'b0, 16'h0010, 2'd0);
        apply_stimulus(1, "s1_fetch1", 1'b1, 1'b0, 1'b0, 16'h0010, 2'd1);
        apply_stimulus(7, "s1_play1",  1'b1, 1'b0, 1'b1, 16'h0020, 2'd1);
        apply_stimulus(1, "s1_gap1",   1'b1, 1'b0, 1'b0, 16'h0020, 2'd1);
        apply_stimulus(1, "s1_fetch2", 1'b1, 1'b0, 1'b0, 16'h0020, 2'd2);
        finish_song("s1", 16'h0020, 2'd2);
        idle_cycles(2, "s1_idle");

        // Rest entry in the middle: enable stays low for its 5 cycles.
        $display("[TB] rest entry");
        rom[0] = ent(16'h0010, 4'd1);
        rom[1] = ent(16'h0000, 4'd1);
        rom[2] = ent(16'h0000, 4'd0);
        rom[3] = ent(16'h0077, 4'd1);
        bus.start = 1'b1;
        apply_stimulus(1, "rest_fetch0", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
        bus.start = 1'b0;
        apply_stimulus(3, "rest_play0",  1'b1, 1'b0, 1'b1, 16'h0010, 2'd0);
        apply_stimulus(1, "rest_gap0",   1'b1, 1'b0, 1'b0, 16'h0010, 2'd0);
        apply_stimulus(1, "rest_fetch1", 1'b1, 1'b0, 1'b0, 16'h0010, 2'd1);
        apply_stimulus(3, "rest_play1",  1'b1, 1'b0, 1'b0, 16'h0000, 2'd1);
        apply_stimulus(1, "rest_gap1",   1'b1, 1'b0, 1'b0, 16'h0000, 2'd1);
        apply_stimulus(1, "rest_fetch2", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd2);
        finish_song("rest", 16'h0000, 2'd2);
        idle_cycles(1, "rest_idle");

        // Full ROM, no marker: END after the last address, no wrap.
        $display("[TB] full rom");
        full_p[0] = 16'h0011;
        full_p[1] = 16'h0022;
        full_p[2] = 16'h0033;
        full_p[3] = 16'h0044;
        for (int k = 0; k < 4; k++) rom[k] = ent(full_p[k], 4'd1);
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1, "full_fetch", 1'b1, 1'b0, 1'b0,
                           (k == 0) ? 16'h0000 : full_p[k-1], ADDR_W'(k));
            bus.start = 1'b0;
            apply_stimulus(3, "full_play", 1'b1, 1'b0, 1'b1, full_p[k], ADDR_W'(k));
            apply_stimulus(1, "full_gap",  1'b1, 1'b0, 1'b0, full_p[k], ADDR_W'(k));
        end
        finish_song("full", 16'h0044, 2'd3);
        idle_cycles(1, "full_idle");

        // stop in the 2nd PLAY cycle; start during PLAY is ignored.
        $display("[TB] stop");
        rom[0] = ent(16'h0010, 4'd2);
        rom[1] = ent(16'h0000, 4'd0);
        bus.start = 1'b1;
        apply_stimulus(1, "stop_fetch", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
        bus.start = 1'b0;
        apply_stimulus(1, "stop_play1", 1'b1, 1'b0, 1'b1, 16'h0010, 2'd0);
        bus.start = 1'b1;
        apply_stimulus(1, "stop_play2", 1'b1, 1'b0, 1'b1, 16'h0010, 2'd0);
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        idle_cycles(1, "stop_idle");
        bus.stop = 1'b0;
        idle_cycles(3, "stop_no_done");

        // Marker at entry 0: single done, back to IDLE in both builds.
        $display("[TB] empty song");
        rom[0] = ent(16'h0099, 4'd0);
        bus.start = 1'b1;
        apply_stimulus(1, "empty_fetch", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
        bus.start = 1'b0;
        apply_stimulus(1, "empty_end",   1'b1, 1'b1, 1'b0, 16'h0000, 2'd0);
        idle_cycles(3, "empty_idle");

`ifdef SONG_SEQ_LOOP_EN
        // Looping: done every 7 cycles, playback restarts at entry 0.
        $display("[TB] loop");
        rom[0] = ent(16'h0010, 4'd1);
        rom[1] = ent(16'h0000, 4'd0);
        bus.start = 1'b1;
        for (int r = 0; r < 2; r++) begin
            apply_stimulus(1, "loop_fetch0", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
            bus.start = 1'b0;
            apply_stimulus(3, "loop_play0",  1'b1, 1'b0, 1'b1, 16'h0010, 2'd0);
            apply_stimulus(1, "loop_gap0",   1'b1, 1'b0, 1'b0, 16'h0010, 2'd0);
            apply_stimulus(1, "loop_fetch1", 1'b1, 1'b0, 1'b0, 16'h0010, 2'd1);
            apply_stimulus(1, "loop_end",    1'b1, 1'b1, 1'b0, 16'h0010, 2'd1);
        end
        apply_stimulus(1, "loop_fetch0", 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0);
        bus.stop = 1'b1;
        idle_cycles(1, "loop_stopped");
        bus.stop = 1'b0;
        idle_cycles(2, "loop_idle");
`endif

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        num_checks++;
        if (exp_q.size() != 0) begin
            num_fail++;
            $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
